ysyx_25020047_lsu_axil: RTL and testbench

Multi-cycle load/store unit that sits between EXU (upstream) and WBU (downstream) and replaces the single-cycle DPI memory path with an AXI4-Lite master port. It accepts one memory request per handshake and performs byte-lane alignment, write-strobe generation, load extraction and sign/zero extension. It delivers the load result or store completion to WBU through a valid/ready handshake. One transaction is outstanding at a time.

---
 rtl/ysyx_25020047_lsu_axil.sv | 132 +++++++++++++
 tb/tb_ysyx_25020047_lsu_axil.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25020047_lsu_axil.sv
// ysyx_25020047_lsu_axil: multi-cycle load/store unit with an AXI4-Lite master port
// Ports: clk, rst (async, active-high); in_* request from EXU (valid/ready handshake);
//        out_* load result / store completion to WBU (valid/ready handshake);
//        ar*/r* AXI4-Lite read channels; aw*/w*/b* AXI4-Lite write channels.
module ysyx_25020047_lsu_axil (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_load,
  input  logic        in_store,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic        out_err,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_t;
  state_t      state_q, state_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d, err_q, err_d;
  logic        mem, mis;
  logic [31:0] st_data, ld_data;
  logic [3:0]  st_strb;
  logic [15:0] lane;
  assign mem = in_load | in_store;
  assign mis = mem & (((in_funct3[1:0] == 2'b01) & in_addr[0]) |
                      ((in_funct3[1:0] == 2'b10) & (in_addr[1:0] != 2'b00)));
  // store data is replicated across lanes so the strobe alone selects the target bytes
  assign st_data = in_funct3[1:0] == 2'b00 ? {4{in_wdata[7:0]}} :
                   in_funct3[1:0] == 2'b01 ? {2{in_wdata[15:0]}} : in_wdata;
  assign st_strb = in_funct3[1:0] == 2'b00 ? 4'b0001 << in_addr[1:0] :
                   in_funct3[1:0] == 2'b01 ? 4'b0011 << {in_addr[1], 1'b0} : 4'b1111;
  // halfwords are always 2-byte aligned here, so a byte-offset shift also picks the half lane
  assign lane    = 16'(rdata >> {addr_q[1:0], 3'b000});
  assign ld_data = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & lane[7]}}, lane[7:0]} :
                   f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & lane[15]}}, lane} : rdata;
  assign in_ready  = state_q == IDLE;
  assign arvalid   = state_q == RD_ADDR;
  assign rready    = state_q == RD_DATA;
  assign bready    = state_q == WR_RESP;
  assign out_valid = state_q == DONE;
  assign araddr    = {addr_q[31:2], 2'b00};
  assign awaddr    = {addr_q[31:2], 2'b00};
  assign awvalid   = awvalid_q;
  assign wvalid    = wvalid_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign out_rdata = rdata_q;
  assign out_err   = err_q;
  always_comb begin
    state_d   = state_q;
    f3_d      = f3_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    awvalid_d = awvalid_q & ~awready;
    wvalid_d  = wvalid_q & ~wready;
    case (state_q)
      IDLE: if (in_valid) begin
        f3_d      = in_funct3;
        addr_d    = in_addr;
        wdata_d   = st_data;
        wstrb_d   = st_strb;
        rdata_d   = '0;
        err_d     = mis;
        awvalid_d = in_store & ~in_load & ~mis;
        wvalid_d  = in_store & ~in_load & ~mis;
        state_d   = (!mem || mis) ? DONE : in_load ? RD_ADDR : WR_REQ;
      end
      RD_ADDR: if (arready) state_d = RD_DATA;
      RD_DATA: if (rvalid) begin
        rdata_d = ld_data;
        err_d   = rresp != 2'b00;
        state_d = DONE;
      end
      WR_REQ: if (!awvalid_d && !wvalid_d) state_d = WR_RESP;
      WR_RESP: if (bvalid) begin
        err_d   = bresp != 2'b00;
        state_d = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      f3_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      f3_q      <= f3_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
    end
  end
endmodule

// File: tb/tb_ysyx_25020047_lsu_axil.sv
// tb_ysyx_25020047_lsu_axil: scoreboard bench with AXI4-Lite slave model for the LSU
module tb_ysyx_25020047_lsu_axil;
  logic clk, rst;
  logic in_valid, in_ready, in_load, in_store;
  logic [2:0] in_funct3;
  logic [31:0] in_addr, in_wdata;
  logic out_valid, out_ready, out_err;
  logic [31:0] out_rdata;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0] rresp, bresp;
  logic [3:0] wstrb;

  ysyx_25020047_lsu_axil dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load), .in_store(in_store),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct { logic [31:0] rdata; logic err; } resp_t;
  typedef struct { bit wr; logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } bus_t;
  resp_t sb_q[$];
  bus_t  bus_q[$];
  int total = 0, bad = 0;
  int ar_dly, r_dly, aw_dly, w_dly, b_dly;
  logic [31:0] r_word;
  logic [1:0] r_resp, b_resp;
  logic [2:0] lf3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", n, act, exp);
    end
  endtask

  task automatic fail(input string n);
    total++;
    bad++;
    $display("FAIL %s: actual=event required=none", n);
  endtask

  // AXI4-Lite slave: inputs are set at the negative edge, sampled by the DUT at the next rising edge
  initial begin
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    bit r_pend, r_drop, b_pend, b_drop, aw_got, w_got;
    {arready, rvalid, awready, wready, bvalid} = '0;
    rdata = 0; rresp = 0; bresp = 0;
    {ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt} = '0;
    {r_pend, r_drop, b_pend, b_drop, aw_got, w_got} = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        {arready, rvalid, awready, wready, bvalid} = '0;
        {ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt} = '0;
        {r_pend, r_drop, b_pend, b_drop, aw_got, w_got} = '0;
      end else begin
        if (r_drop) begin rvalid = 0; r_drop = 0; end
        if (!rvalid && r_pend) begin
          if (r_cnt >= r_dly) begin rvalid = 1; rdata = r_word; rresp = r_resp; end
          else r_cnt++;
        end
        if (rvalid && rready) begin r_drop = 1; r_pend = 0; r_cnt = 0; end
        if (b_drop) begin bvalid = 0; b_drop = 0; end
        if (!bvalid && b_pend) begin
          if (b_cnt >= b_dly) begin bvalid = 1; bresp = b_resp; end
          else b_cnt++;
        end
        if (bvalid && bready) begin b_drop = 1; b_pend = 0; b_cnt = 0; end
        arready = arvalid && ar_cnt >= ar_dly;
        if (arvalid && !arready) ar_cnt++;
        if (arvalid && arready) begin
          ar_cnt = 0;
          if (bus_q.size() == 0 || bus_q[0].wr) fail("unexpected_ar");
          else begin
            chk("araddr", araddr, bus_q[0].addr);
            void'(bus_q.pop_front());
            r_pend = 1;
          end
        end
        awready = awvalid && aw_cnt >= aw_dly;
        if (awvalid && !awready) aw_cnt++;
        if (awvalid && awready) begin
          aw_cnt = 0;
          if (bus_q.size() == 0 || !bus_q[0].wr) fail("unexpected_aw");
          else begin chk("awaddr", awaddr, bus_q[0].addr); aw_got = 1; end
        end
        wready = wvalid && w_cnt >= w_dly;
        if (wvalid && !wready) w_cnt++;
        if (wvalid && wready) begin
          w_cnt = 0;
          if (bus_q.size() == 0 || !bus_q[0].wr) fail("unexpected_w");
          else begin
            chk("wdata", wdata, bus_q[0].data);
            chk("wstrb", {28'h0, wstrb}, {28'h0, bus_q[0].strb});
            w_got = 1;
          end
        end
        if (aw_got && w_got) begin
          void'(bus_q.pop_front());
          aw_got = 0; w_got = 0; b_pend = 1;
        end
      end
    end
  end

  // result monitor
  initial begin
    resp_t em;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb_q.size() == 0) fail("unexpected_out");
        else begin
          em = sb_q.pop_front();
          chk("out_rdata", out_rdata, em.rdata);
          chk("out_err", {31'h0, out_err}, {31'h0, em.err});
        end
      end
    end
  end

  // reference model: computes the expected response/bus beat and drives one request
  task automatic start(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] word, input logic [1:0] rr,
                       input logic [1:0] br, output int lat);
    int n = 1 << f3[1:0];
    int k = 0;
    bit mis = (ld || st) && (a % n != 0);
    logic [31:0] v;
    resp_t e;
    bus_t b;
    lat = 0;
    if (!ld && !st) begin e = '{32'h0, 1'b0}; lat = 1; end
    else if (mis) begin e = '{32'h0, 1'b1}; lat = 1; end
    else if (ld) begin
      v = word >> (8 * (a % 4));
      case (f3)
        3'b000: v = (v & 32'hFF) | ((v & 32'h80) != 0 ? 32'hFFFFFF00 : 32'h0);
        3'b001: v = (v & 32'hFFFF) | ((v & 32'h8000) != 0 ? 32'hFFFF0000 : 32'h0);
        3'b100: v = v & 32'hFF;
        3'b101: v = v & 32'hFFFF;
        default: v = word;
      endcase
      e = '{v, rr != 2'b00};
      b = '{1'b0, a & ~32'h3, 32'h0, 4'h0};
      bus_q.push_back(b);
      if (ar_dly == 0 && r_dly == 0) lat = 3;
    end else begin
      e = '{32'h0, br != 2'b00};
      v = f3 == 3'b000 ? (wd & 32'hFF) * 32'h01010101 :
          f3 == 3'b001 ? (wd & 32'hFFFF) * 32'h00010001 : wd;
      b = '{1'b1, a & ~32'h3, v, 4'((((1 << n) - 1) << (a % 4)))};
      bus_q.push_back(b);
      if (aw_dly == 0 && w_dly == 0 && b_dly == 0) lat = 3;
    end
    r_word = word; r_resp = rr; b_resp = br;
    sb_q.push_back(e);
    while (!in_ready && k < 100) begin @(posedge clk); #1; k++; end
    if (!in_ready) fail("in_ready_timeout");
    in_valid = 1; in_load = ld; in_store = st; in_funct3 = f3; in_addr = a; in_wdata = wd;
    @(posedge clk); #1;
    in_valid = 0; in_load = 0; in_store = 0;
    in_funct3 = 3'($urandom); in_addr = $urandom; in_wdata = $urandom;
    chk("accepted_in_ready", {31'h0, in_ready}, 32'h0);
  endtask

  task automatic wait_done(input int exp_lat);
    int lat = 1;
    int k = 0;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    if (exp_lat > 0) chk("latency", lat, exp_lat);
    while (sb_q.size() != 0 && k < 200) begin @(posedge clk); #1; k++; end
    if (sb_q.size() != 0) begin fail("done_timeout"); sb_q.delete(); end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int lat, k, kind;
    bit ld, st;
    logic [2:0] f3;
    logic [31:0] a;
    logic [1:0] rr, br;
    rst = 1; in_valid = 0; in_load = 0; in_store = 0; in_funct3 = 0; in_addr = 0; in_wdata = 0;
    out_ready = 1;
    {ar_dly, r_dly, aw_dly, w_dly, b_dly} = '0;
    r_word = 0; r_resp = 0; b_resp = 0;
    #12;
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_valids", {26'h0, arvalid, awvalid, wvalid, rready, bready, out_valid}, 32'h0);
    chk("rst_out", {31'h0, out_err} | out_rdata, 32'h0);
    chk("rst_araddr", araddr, 32'h0);
    chk("rst_awaddr", awaddr, 32'h0);
    chk("rst_wdata", wdata, 32'h0);
    chk("rst_wstrb", {28'h0, wstrb}, 32'h0);
    @(posedge clk); #1; rst = 0;
    @(posedge clk); #1;

    start(1, 0, 3'b000, 32'h80000003, 0, 32'h80FF1234, 2'b00, 2'b00, lat); wait_done(lat);
    start(1, 0, 3'b101, 32'h80000002, 0, 32'hBEEF0000, 2'b00, 2'b00, lat); wait_done(lat);
    start(1, 0, 3'b010, 32'h80000001, 0, 32'h11111111, 2'b00, 2'b00, lat); wait_done(lat);
    start(0, 0, 3'b010, 32'h80000004, 0, 32'h0, 2'b00, 2'b00, lat); wait_done(lat);
    start(0, 1, 3'b001, 32'h80000003, 32'h5555, 0, 2'b00, 2'b00, lat); wait_done(lat);
    aw_dly = 3;
    start(0, 1, 3'b000, 32'h80000001, 32'h000000AB, 0, 2'b00, 2'b00, lat); wait_done(lat);
    aw_dly = 0;
    start(0, 1, 3'b001, 32'h80000002, 32'h00001234, 0, 2'b00, 2'b10, lat); wait_done(lat);
    start(0, 1, 3'b010, 32'h80000008, 32'hCAFEF00D, 0, 2'b00, 2'b00, lat); wait_done(lat);
    start(1, 0, 3'b010, 32'h8000000C, 0, 32'h76543210, 2'b11, 2'b00, lat); wait_done(lat);

    // WBU back-pressure while a result is held
    out_ready = 0;
    start(1, 0, 3'b000, 32'h80000007, 0, 32'h92345678, 2'b00, 2'b00, lat);
    k = 0;
    while (!out_valid && k < 50) begin @(posedge clk); #1; k++; end
    for (int i = 0; i < 5; i++) begin
      chk("stall_out_valid", {31'h0, out_valid}, 32'h1);
      chk("stall_out_rdata", out_rdata, sb_q.size() != 0 ? sb_q[0].rdata : 32'hFFFFFFFF);
      chk("stall_in_ready", {31'h0, in_ready}, 32'h0);
      @(posedge clk); #1;
    end
    out_ready = 1;
    @(posedge clk); #1;
    chk("in_ready_after_done", {31'h0, in_ready}, 32'h1);
    chk("stall_popped", sb_q.size(), 0);
    start(1, 0, 3'b100, 32'h80000005, 0, 32'h0000F000, 2'b00, 2'b00, lat); wait_done(lat);

    // reset while waiting for read data
    r_dly = 6;
    start(1, 0, 3'b010, 32'h80000020, 0, 32'h12121212, 2'b00, 2'b00, lat);
    k = 0;
    while (!rready && k < 50) begin @(posedge clk); #1; k++; end
    chk("reached_rd_data", {31'h0, rready}, 32'h1);
    rst = 1;
    #1;
    chk("midrst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("midrst_valids", {26'h0, arvalid, awvalid, wvalid, rready, bready, out_valid}, 32'h0);
    sb_q.delete(); bus_q.delete();
    @(posedge clk); #1; rst = 0; r_dly = 0;
    start(1, 0, 3'b010, 32'h80000010, 0, 32'hDEADBEEF, 2'b00, 2'b00, lat); wait_done(lat);

    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 5);
      ld = kind >= 1 && kind <= 3;
      st = kind >= 4;
      f3 = ld ? lf3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
      a = 32'h80000000 | 32'($urandom_range(0, 255));
      rr = $urandom_range(0, 3) == 0 ? 2'($urandom_range(1, 3)) : 2'b00;
      br = $urandom_range(0, 3) == 0 ? 2'($urandom_range(1, 3)) : 2'b00;
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
      start(ld, st, f3, a, $urandom, $urandom, rr, br, lat);
      wait_done(lat);
    end
    chk("bus_q_drained", bus_q.size(), 0);
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
